shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal register: `W`-bit edge-triggered storage with enable, parallel load, shift and rotate modes, serial in/out, and status flags. It is the clocked, configurable successor to the team's 8-bit gated-latch register bank. It is the general-purpose storage/shift element for datapath and serial-conversion lab blocks.

## Interface
- `W`, default 8: register width in bits; legal range ≥ 2.
- `RST_VAL`, default 0: value loaded into the register on reset and by the CLR mode (`W` bits).
- `CLK` input 1: clock; all state changes on the rising edge.
- `R` input 1: reset; synchronous, active-high.
- `E` input 1: enable. When 0, the register holds and the mode is ignored.
- `M` input 3: mode select; decoded only when `E`=1.
- `D` input `W`: parallel load data.
- `SIL` input 1: serial in, fills the LSB on a left shift.
- `SIR` input 1: serial in, fills the MSB on a logical right shift.
- `Q` output `W`: register contents.
- `Qn` output `W`: bitwise complement of `Q`, always.
- `SOUT` output 1: bit shifted out by the last shift or rotate operation.
- `Z` output 1: 1 when `Q` is all zeros (combinational from `Q`).
- `P` output 1: even parity of `Q`, i.e. the XOR of all bits (combinational from `Q`).

## Operation
- Register state is `Q[W-1:0]` plus the `SOUT` flop. `Qn`, `Z` and `P` are derived combinationally.
- Priority at each rising edge is: `R` first, then `E`=0 (hold), then the mode in `M`.
- Modes when `E`=1:
  - 000 HOLD: `Q` and `SOUT` unchanged.
  - 001 LOAD: `Q`←`D`. `SOUT` unchanged.
  - 010 SHL: `Q`←{`Q[W-2:0]`,`SIL`}. `SOUT`←old `Q[W-1]`.
  - 011 SHR: `Q`←{`SIR`,`Q[W-1:1]`}. `SOUT`←old `Q[0]`.
  - 100 ASR: `Q`←{`Q[W-1]`,`Q[W-1:1]`}, sign preserved; `SIR` is ignored. `SOUT`←old `Q[0]`.
  - 101 ROL: `Q`←{`Q[W-2:0]`,`Q[W-1]`}. `SOUT`←old `Q[W-1]`.
  - 110 ROR: `Q`←{`Q[0]`,`Q[W-1:1]`}. `SOUT`←old `Q[0]`.
  - 111 CLR: `Q`←`RST_VAL`, `SOUT`←0.
- No X propagation from an unused serial input. In SHL only `SIL` is sampled; in SHR only `SIR` is sampled.
- The block has no internal FSM beyond the register itself. Sequences such as 8 consecutive SHRs perform serial-to-parallel conversion, driven externally.

## Timing
- Reset: at the first rising edge with `R`=1, `Q`=`RST_VAL` and `SOUT`=0. With `RST_VAL`=0 this gives `Qn`=all ones, `Z`=1, `P`=0.
- Before the first reset edge, outputs are undefined. The bench must not check them.
- Latency: one cycle. A mode applied before edge k is visible on `Q` and `SOUT` just after edge k.
- `Qn`, `Z` and `P` settle in the same cycle as `Q`; they have no extra register stage.
- Simultaneous events:
  - `R`=1 with any `E`/`M` value: reset wins.
  - `E`=0 with any `M` value: hold, and `SOUT` is also held.
- Reset mid-sequence: an `R` pulse in the middle of a shift run discards the partial data. The next edge after `R` falls resumes from `RST_VAL`.
- Wrap-around:
  - `W` consecutive ROLs (or RORs) return `Q` to its original value.
  - `W` SHLs with `SIL`=0 give `Q`=0 and `Z`=1.
  - `W` ASRs of a negative value give all ones.
- Inputs are sampled only at the rising edge. Glitches between edges have no effect, unlike the previous latch-based register.

## Test plan
- Reset and load:
  - Assert `R` for 1 cycle → `Q`=0x00, `Qn`=0xFF, `Z`=1, `P`=0, `SOUT`=0.
  - LOAD `D`=0xA5 → `Q`=0xA5, `Qn`=0x5A, `P`=0, `Z`=0.
- Shift left/right:
  - From 0x81, SHL with `SIL`=1 → `Q`=0x03, `SOUT`=1.
  - From 0x81, SHR with `SIR`=0 → `Q`=0x40, `SOUT`=1.
- Arithmetic and rotate:
  - From 0x90, ASR → `Q`=0xC8.
  - From 0x90, apply 8 ROLs → `Q`=0x90, and `SOUT` follows the sequence 1,0,0,1,0,0,0,0.
- Serial conversion: starting from `Q`=0x00, present `SIR` = 1,0,1,1,0,0,1,0 over 8 SHR cycles → `Q`=0x4D.
- Enable and priority:
  - `E`=0 with `M`=LOAD, `D`=0xFF → `Q` unchanged.
  - `R`=1 together with `E`=1, `M`=LOAD → `Q`=`RST_VAL`.
  - CLR with `RST_VAL`=0x3C (second instance) → `Q`=0x3C, `SOUT`=0.
- Parametrisation: at `W`=16, load 0x8001 then apply 16 RORs → `Q`=0x8001; a following ASR → `Q`=0xC000, `SOUT`=1.

Source files
------------

// File: rtl/shift_reg_univ_if.sv
// Data/status bundle for shift_reg_univ: controls and data in, register view and flags out.
interface shift_reg_univ_if #(
  parameter int W = 8
);
  logic         E;
  logic [2:0]   M;
  logic [W-1:0] D;
  logic         SIL;
  logic         SIR;
  logic [W-1:0] Q;
  logic [W-1:0] Qn;
  logic         SOUT;
  logic         Z;
  logic         P;

  modport master (output E, M, D, SIL, SIR, input Q, Qn, SOUT, Z, P);
  modport slave  (input E, M, D, SIL, SIR, output Q, Qn, SOUT, Z, P);
endinterface

// File: rtl/shift_reg_univ.sv
// Universal W-bit register: load, logical/arithmetic shift, rotate, clear, with serial out and flags.
// Built from one bit cell per position; the top only decodes the mode and wires neighbours.
module sru_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ld,
  input  logic go_lo,
  input  logic go_hi,
  input  logic clr,
  input  logic rst_bit,
  input  logic d,
  input  logic lo,
  input  logic hi,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)        q <= rst_bit;
    else if (en) begin
      if (clr)        q <= rst_bit;
      else if (ld)    q <= d;
      else if (go_lo) q <= lo;
      else if (go_hi) q <= hi;
    end
  end
endmodule

module shift_reg_univ #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             R,
  shift_reg_univ_if.slave  bus
);
  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ASR  = 3'd4;
  localparam logic [2:0] M_ROL  = 3'd5;
  localparam logic [2:0] M_ROR  = 3'd6;
  localparam logic [2:0] M_CLR  = 3'd7;

  logic [W-1:0] q, lo_in, hi_in;
  logic         ld, go_lo, go_hi, clr, sout;

  always_comb begin
    ld    = 1'b0;
    go_lo = 1'b0;
    go_hi = 1'b0;
    clr   = 1'b0;
    case (bus.M)
      M_LOAD:                go_lo = 1'b0;
      M_SHL, M_ROL:          go_lo = 1'b1;
      M_SHR, M_ASR, M_ROR:   go_hi = 1'b1;
      M_CLR:                 clr   = 1'b1;
      default:               ;
    endcase
    if (bus.M == M_LOAD) ld = 1'b1;
  end

  // Only the boundary bits differ between shift flavours; the unused serial input is never selected.
  assign lo_in = {q[W-2:0], (bus.M == M_ROL) ? q[W-1] : bus.SIL};
  assign hi_in = {(bus.M == M_SHR) ? bus.SIR : (bus.M == M_ASR) ? q[W-1] : q[0], q[W-1:1]};

  for (genvar i = 0; i < W; i++) begin : g_bit
    sru_bit_cell u_cell (
      .clk    (CLK),
      .rst    (R),
      .en     (bus.E),
      .ld     (ld),
      .go_lo  (go_lo),
      .go_hi  (go_hi),
      .clr    (clr),
      .rst_bit(RST_VAL[i]),
      .d      (bus.D[i]),
      .lo     (lo_in[i]),
      .hi     (hi_in[i]),
      .q      (q[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (R)          sout <= 1'b0;
    else if (bus.E) begin
      case (bus.M)
        M_SHL, M_ROL:        sout <= q[W-1];
        M_SHR, M_ASR, M_ROR: sout <= q[0];
        M_CLR:               sout <= 1'b0;
        default:             sout <= sout;
      endcase
    end
  end

  assign bus.Q    = q;
  assign bus.Qn   = ~q;
  assign bus.SOUT = sout;
  assign bus.Z    = ~|q;
  assign bus.P    = ^q;

  logic unused_hold;
  assign unused_hold = (M_HOLD == 3'd0);
endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: three instances (W=8, W=8 with RST_VAL=0x3C, W=16) against an arithmetic model.
module tb_shift_reg_univ;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_reg_univ_if #(.W(8))  if0 ();
  shift_reg_univ_if #(.W(8))  if1 ();
  shift_reg_univ_if #(.W(16)) if2 ();

  shift_reg_univ #(.W(8),  .RST_VAL(8'h00))    dut0 (.CLK(clk), .R(rst), .bus(if0));
  shift_reg_univ #(.W(8),  .RST_VAL(8'h3C))    dut1 (.CLK(clk), .R(rst), .bus(if1));
  shift_reg_univ #(.W(16), .RST_VAL(16'h0000)) dut2 (.CLK(clk), .R(rst), .bus(if2));

  localparam logic [2:0] HOLD = 0, LOAD = 1, SHL = 2, SHR = 3, ASR = 4, ROL = 5, ROR = 6, CLR = 7;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wid[3] = '{8, 8, 16};
  logic [15:0] rvv[3] = '{16'h0000, 16'h003C, 16'h0000};
  logic [15:0] mq[3];
  logic        ms[3];

  // Reference: next {sout, q} from plain shifts/masks on an integer view of the register.
  function automatic logic [16:0] ref_next(int w, logic [15:0] rv, logic [15:0] q, logic so,
                                           logic r, logic e, logic [2:0] m, logic [15:0] d,
                                           logic sil, logic sir);
    int unsigned mask = (32'd1 << w) - 1;
    int unsigned qi   = 32'(q);
    int unsigned msb  = (qi >> (w - 1)) & 1;
    int unsigned lsb  = qi & 1;
    int unsigned nq   = qi;
    logic        ns   = so;
    if (r) begin nq = 32'(rv); ns = 1'b0; end
    else if (e) begin
      case (m)
        LOAD: nq = 32'(d) & mask;
        SHL:  begin nq = ((qi << 1) | 32'(sil)) & mask; ns = msb[0]; end
        SHR:  begin nq = (qi >> 1) | (32'(sir) << (w - 1)); ns = lsb[0]; end
        ASR:  begin nq = (qi >> 1) | (msb << (w - 1)); ns = lsb[0]; end
        ROL:  begin nq = ((qi << 1) | msb) & mask; ns = msb[0]; end
        ROR:  begin nq = (qi >> 1) | (lsb << (w - 1)); ns = lsb[0]; end
        CLR:  begin nq = 32'(rv); ns = 1'b0; end
        default: ;
      endcase
    end
    return {ns, nq[15:0]};
  endfunction

  // One clock: instance k gets the given controls, the others get E=0 with junk mode/data.
  task automatic step(input int k, input logic r, input logic e, input logic [2:0] m,
                      input logic [15:0] d, input logic sil, input logic sir);
    logic        ee[3], sl[3], sr[3];
    logic [2:0]  mm[3];
    logic [15:0] dd[3];
    logic [16:0] nx[3];
    for (int j = 0; j < 3; j++) begin
      if (j == k) begin ee[j] = e; mm[j] = m; dd[j] = d; sl[j] = sil; sr[j] = sir; end
      else begin
        ee[j] = 1'b0; mm[j] = 3'($urandom); dd[j] = 16'($urandom);
        sl[j] = 1'($urandom); sr[j] = 1'($urandom);
      end
    end
    rst = r;
    if0.E = ee[0]; if0.M = mm[0]; if0.D = dd[0][7:0]; if0.SIL = sl[0]; if0.SIR = sr[0];
    if1.E = ee[1]; if1.M = mm[1]; if1.D = dd[1][7:0]; if1.SIL = sl[1]; if1.SIR = sr[1];
    if2.E = ee[2]; if2.M = mm[2]; if2.D = dd[2];      if2.SIL = sl[2]; if2.SIR = sr[2];
    for (int j = 0; j < 3; j++)
      nx[j] = ref_next(wid[j], rvv[j], mq[j], ms[j], r, ee[j], mm[j], dd[j], sl[j], sr[j]);
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) {ms[j], mq[j]} = nx[j];
    rst = 1'b0;
  endtask

  task automatic sample(input int k, output logic [15:0] q, output logic [15:0] qn,
                        output logic so, output logic z, output logic p);
    case (k)
      0:       begin q = {8'h00, if0.Q}; qn = {8'h00, if0.Qn}; so = if0.SOUT; z = if0.Z; p = if0.P; end
      1:       begin q = {8'h00, if1.Q}; qn = {8'h00, if1.Qn}; so = if1.SOUT; z = if1.Z; p = if1.P; end
      default: begin q = if2.Q;          qn = if2.Qn;          so = if2.SOUT; z = if2.Z; p = if2.P; end
    endcase
  endtask

  task automatic test_reset;
    step(0, 1'b1, 1'b1, LOAD, 16'h00FF, 1'b1, 1'b1);
    n_cmp++; if (if0.Q !== 8'h00)  begin n_bad++; $display("FAIL reset_q got %h want 00", if0.Q); end
    n_cmp++; if (if0.Qn !== 8'hFF) begin n_bad++; $display("FAIL reset_qn got %h want ff", if0.Qn); end
    n_cmp++; if (if0.Z !== 1'b1)   begin n_bad++; $display("FAIL reset_z got %b want 1", if0.Z); end
    n_cmp++; if (if0.P !== 1'b0)   begin n_bad++; $display("FAIL reset_p got %b want 0", if0.P); end
    n_cmp++; if (if0.SOUT !== 1'b0) begin n_bad++; $display("FAIL reset_sout got %b want 0", if0.SOUT); end
    n_cmp++; if (if1.Q !== 8'h3C)  begin n_bad++; $display("FAIL reset_q_rv got %h want 3c", if1.Q); end
    n_cmp++; if (if2.Q !== 16'h0)  begin n_bad++; $display("FAIL reset_q16 got %h want 0000", if2.Q); end
  endtask

  task automatic test_load;
    step(0, 1'b0, 1'b1, LOAD, 16'h00A5, 1'b0, 1'b0);
    n_cmp++; if (if0.Q !== 8'hA5)  begin n_bad++; $display("FAIL load_q got %h want a5", if0.Q); end
    n_cmp++; if (if0.Qn !== 8'h5A) begin n_bad++; $display("FAIL load_qn got %h want 5a", if0.Qn); end
    n_cmp++; if (if0.P !== 1'b0)   begin n_bad++; $display("FAIL load_p got %b want 0", if0.P); end
    n_cmp++; if (if0.Z !== 1'b0)   begin n_bad++; $display("FAIL load_z got %b want 0", if0.Z); end
  endtask

  task automatic test_shift;
    step(0, 1'b0, 1'b1, LOAD, 16'h0081, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, SHL, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (if0.Q !== 8'h03)  begin n_bad++; $display("FAIL shl_q got %h want 03", if0.Q); end
    n_cmp++; if (if0.SOUT !== 1'b1) begin n_bad++; $display("FAIL shl_sout got %b want 1", if0.SOUT); end
    step(0, 1'b0, 1'b1, LOAD, 16'h0081, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, SHR, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (if0.Q !== 8'h40)  begin n_bad++; $display("FAIL shr_q got %h want 40", if0.Q); end
    n_cmp++; if (if0.SOUT !== 1'b1) begin n_bad++; $display("FAIL shr_sout got %b want 1", if0.SOUT); end
  endtask

  task automatic test_asr_rotate;
    logic [7:0] exp_so = 8'b1001_0000;
    step(0, 1'b0, 1'b1, LOAD, 16'h0090, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, ASR, 16'h0000, 1'b0, 1'b0);
    n_cmp++; if (if0.Q !== 8'hC8) begin n_bad++; $display("FAIL asr_q got %h want c8", if0.Q); end
    step(0, 1'b0, 1'b1, LOAD, 16'h0090, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b0, 1'b1, ROL, 16'h0000, 1'b0, 1'b0);
      n_cmp++;
      if (if0.SOUT !== exp_so[7-i]) begin
        n_bad++; $display("FAIL rol_sout[%0d] got %b want %b", i, if0.SOUT, exp_so[7-i]);
      end
    end
    n_cmp++; if (if0.Q !== 8'h90) begin n_bad++; $display("FAIL rol_wrap got %h want 90", if0.Q); end
    step(0, 1'b0, 1'b1, LOAD, 16'h0080, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(0, 1'b0, 1'b1, ASR, 16'h0000, 1'b0, 1'b0);
    n_cmp++; if (if0.Q !== 8'hFF) begin n_bad++; $display("FAIL asr_wrap got %h want ff", if0.Q); end
  endtask

  task automatic test_serial;
    logic [7:0] bits = 8'b1011_0010;
    step(0, 1'b0, 1'b1, CLR, 16'h00FF, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(0, 1'b0, 1'b1, SHR, 16'h0000, ~bits[7-i], bits[7-i]);
    n_cmp++; if (if0.Q !== 8'h4D) begin n_bad++; $display("FAIL serial_q got %h want 4d", if0.Q); end
  endtask

  task automatic test_enable_priority;
    step(0, 1'b0, 1'b1, LOAD, 16'h0081, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, SHL, 16'h0000, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, LOAD, 16'h00FF, 1'b0, 1'b0);
    n_cmp++; if (if0.Q !== 8'h02)   begin n_bad++; $display("FAIL en0_q got %h want 02", if0.Q); end
    n_cmp++; if (if0.SOUT !== 1'b1) begin n_bad++; $display("FAIL en0_sout got %b want 1", if0.SOUT); end
    step(0, 1'b1, 1'b1, LOAD, 16'h00FF, 1'b0, 1'b0);
    n_cmp++; if (if0.Q !== 8'h00) begin n_bad++; $display("FAIL rst_over_load got %h want 00", if0.Q); end
    step(1, 1'b0, 1'b1, LOAD, 16'h0081, 1'b0, 1'b0);
    step(1, 1'b0, 1'b1, SHL, 16'h0000, 1'b0, 1'b0);
    step(1, 1'b0, 1'b1, CLR, 16'h00FF, 1'b1, 1'b1);
    n_cmp++; if (if1.Q !== 8'h3C)   begin n_bad++; $display("FAIL clr_q got %h want 3c", if1.Q); end
    n_cmp++; if (if1.SOUT !== 1'b0) begin n_bad++; $display("FAIL clr_sout got %b want 0", if1.SOUT); end
  endtask

  task automatic test_reset_mid;
    step(1, 1'b0, 1'b1, LOAD, 16'h00F0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b1, SHL, 16'h0000, 1'b1, 1'b0);
    step(1, 1'b1, 1'b1, SHL, 16'h0000, 1'b1, 1'b0);
    step(1, 1'b0, 1'b1, SHL, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (if1.Q !== 8'h79) begin n_bad++; $display("FAIL reset_mid got %h want 79", if1.Q); end
  endtask

  task automatic test_param16;
    step(2, 1'b0, 1'b1, LOAD, 16'h8001, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(2, 1'b0, 1'b1, ROR, 16'h0000, 1'b0, 1'b0);
    n_cmp++; if (if2.Q !== 16'h8001) begin n_bad++; $display("FAIL ror16 got %h want 8001", if2.Q); end
    step(2, 1'b0, 1'b1, ASR, 16'h0000, 1'b0, 1'b1);
    n_cmp++; if (if2.Q !== 16'hC000) begin n_bad++; $display("FAIL asr16_q got %h want c000", if2.Q); end
    n_cmp++; if (if2.SOUT !== 1'b1)  begin n_bad++; $display("FAIL asr16_sout got %b want 1", if2.SOUT); end
    for (int i = 0; i < 16; i++) step(2, 1'b0, 1'b1, SHL, 16'h0000, 1'b0, 1'b1);
    n_cmp++; if (if2.Z !== 1'b1) begin n_bad++; $display("FAIL shl16_z got %b want 1 (q=%h)", if2.Z, if2.Q); end
  endtask

  task automatic test_random;
    logic [15:0] q, qn, mask;
    logic        so, z, p;
    int          k;
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 2);
      step(k, ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 5) != 0), 3'($urandom),
           16'($urandom), 1'($urandom), 1'($urandom));
      sample(k, q, qn, so, z, p);
      mask = (k == 2) ? 16'hFFFF : 16'h00FF;
      n_cmp++; if (q !== mq[k])           begin n_bad++; $display("FAIL rnd_q[%0d] inst%0d got %h want %h", n, k, q, mq[k]); end
      n_cmp++; if (qn !== (~mq[k] & mask)) begin n_bad++; $display("FAIL rnd_qn[%0d] inst%0d got %h want %h", n, k, qn, ~mq[k] & mask); end
      n_cmp++; if (so !== ms[k])          begin n_bad++; $display("FAIL rnd_sout[%0d] inst%0d got %b want %b", n, k, so, ms[k]); end
      n_cmp++; if (z !== (mq[k] == 16'h0)) begin n_bad++; $display("FAIL rnd_z[%0d] inst%0d got %b", n, k, z); end
      n_cmp++; if (p !== 1'($countones(mq[k]) % 2)) begin n_bad++; $display("FAIL rnd_p[%0d] inst%0d got %b", n, k, p); end
    end
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin mq[j] = 'x; ms[j] = 1'bx; end
    if0.E = 0; if0.M = 0; if0.D = 0; if0.SIL = 0; if0.SIR = 0;
    if1.E = 0; if1.M = 0; if1.D = 0; if1.SIL = 0; if1.SIR = 0;
    if2.E = 0; if2.M = 0; if2.D = 0; if2.SIL = 0; if2.SIR = 0;
    @(negedge clk);
    test_reset;
    test_load;
    test_shift;
    test_asr_rotate;
    test_serial;
    test_enable_priority;
    test_reset_mid;
    test_param16;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
